// File: rtl/regfile_wb_arbiter.sv
// Round-robin owner of the single register-file write port (ALU, load, I/O, link).
// Build option: define REG_ZERO_PROTECT_EN to make writes to register 0 no-ops.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [3:0]        dest0,
  input  logic [3:0]        dest1,
  input  logic [3:0]        dest2,
  input  logic [3:0]        dest3,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic              stall,
  output logic [3:0]        gnt,
  output logic              wr_en,
  output logic [3:0]        wr_dest,
  output logic [NREG-1:0]   wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nx;
  logic [1:0]        ptr;
  logic [1:0]        ptr_nx;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic [3:0]        ereq;
  logic [3:0]        gnt_nx;
  logic              found;
  logic              take;
  logic              wr_ok;
  logic              en_nx;
  logic [3:0]        dsel;
  logic [3:0]        dest_nx;
  logic [DATA_W-1:0] dsel_data;
  logic [DATA_W-1:0] data_nx;
  logic [NREG-1:0]   sel_nx;

  // A requester sitting in its grant cycle is masked so it is never granted twice.
  assign ereq = req & ~gnt;

  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && ereq[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    dsel      = dest0;
    dsel_data = data0;
    unique case (win)
      2'd0: begin
        dsel      = dest0;
        dsel_data = data0;
      end
      2'd1: begin
        dsel      = dest1;
        dsel_data = data1;
      end
      2'd2: begin
        dsel      = dest2;
        dsel_data = data2;
      end
      2'd3: begin
        dsel      = dest3;
        dsel_data = data3;
      end
      default: begin
        dsel      = dest0;
        dsel_data = data0;
      end
    endcase
  end

`ifdef REG_ZERO_PROTECT_EN
  assign wr_ok = (dsel != 4'd0);
`else
  assign wr_ok = 1'b1;
`endif

  // A blocked register-0 grant leaves wr_en low, so stall cannot hold it.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gnt_nx   = 4'b0000;
    en_nx    = wr_en;
    dest_nx  = wr_dest;
    data_nx  = wr_data;
    sel_nx   = wr_sel;
    take     = 1'b0;
    unique case (state)
      IDLE:    take = !stall;
      WRITE:   take = !(stall && wr_en);
      HOLD:    take = !(stall && wr_en);
      default: take = 1'b0;
    endcase
    if (take) begin
      if (found) begin
        state_nx = WRITE;
        ptr_nx   = win + 2'd1;
        gnt_nx   = 4'b0001 << win;
        en_nx    = wr_ok;
        dest_nx  = dsel;
        data_nx  = dsel_data;
        sel_nx   = wr_ok ? (ONE << dsel) : '0;
      end else begin
        state_nx = IDLE;
        en_nx    = 1'b0;
        sel_nx   = '0;
      end
    end else if (state == WRITE) begin
      state_nx = HOLD;
    end else if (state != HOLD && state != IDLE) begin
      state_nx = IDLE;
      en_nx    = 1'b0;
      sel_nx   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      gnt     <= 4'b0000;
      wr_en   <= 1'b0;
      wr_dest <= 4'd0;
      wr_data <= '0;
      wr_sel  <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      gnt     <= gnt_nx;
      wr_en   <= en_nx;
      wr_dest <= dest_nx;
      wr_data <= data_nx;
      wr_sel  <= sel_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between four writeback requesters: 0 = ALU, 1 = load unit, 2 = I/O, 3 = control/link.
- Selects one requester per cycle by round-robin and registers its destination and data.
- Drives the 16-bit one-hot register write-enable bus plus the data and destination bus.
- Sits between the execute/memory stages and the register file; supplies the write port's timing and ownership.

Parameters:
- DATA_W, 16, width of writeback data.
- NREG, 16, number of registers; equals 2^4 and fixes the one-hot width of wr_sel.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  per-requester write request, level; held until granted.
- dest0..dest3  in  4 each  destination register index of requester i.
- data0..data3  in  DATA_W each  write data of requester i.
- stall  in  1  register file cannot accept a write this cycle.
- gnt  out  4  one-cycle grant pulse; at most one bit set.
- wr_en  out  1  register-file write strobe.
- wr_dest  out  4  registered destination index.
- wr_sel  out  NREG  one-hot write enable: bit wr_dest set when wr_en=1, all zero otherwise.
- wr_data  out  DATA_W  registered write data.
- busy  out  1  high in WRITE or HOLD.

Behaviour:
- Reset (async, immediate): state=IDLE, ptr=0, gnt=0, wr_en=0, wr_sel=0, wr_dest=0, wr_data=0, busy=0. Reset mid-HOLD discards the pending write; no grant is reissued.
- Effective request: ereq = req & ~gnt. A requester granted this cycle is masked, so a req still high during its gnt cycle is not granted twice.
- Priority: search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set ereq bit wins. On every grant, ptr <= winner+1 mod 4. ptr never moves without a grant.
- Latency: a request sampled at edge t yields gnt, wr_en, wr_dest, wr_data and wr_sel all valid in cycle t+1, all registered.
- Requester protocol:
  - Drop req, or present a new dest/data, in the cycle gnt is seen.
  - dest/data must be stable while req is high.
- FSM:
  - IDLE: wr_en=0. If !stall and |ereq: grant the winner and go to WRITE. Otherwise stay in IDLE.
  - WRITE: wr_en=1 for one cycle.
    - If stall=1: go to HOLD and keep wr_en, wr_dest, wr_data, wr_sel unchanged; gnt=0.
    - Else if |ereq: grant the next winner and stay in WRITE (back-to-back, one write per cycle).
    - Else: go to IDLE.
  - HOLD: outputs frozen, gnt=0, no grants. When stall=0, the held write completes in that cycle, then the next state is chosen as from WRITE with stall=0 (new grant, or IDLE).
- Stall in IDLE: no grant issued and ptr unchanged.
- Simultaneous requests: exactly one grant per edge. The rest stay pending without loss.
- Fairness: under continuous requests from all four, each is granted once in every 4 consecutive grants.
- wr_sel is the 4-to-16 decode of the next wr_dest, gated by the next wr_en, and registered alongside them.

Optional Feature:
- Macro: REG_ZERO_PROTECT_EN.
- Defined: register 0 is hardwired.
  - A grant whose dest=0 still pulses gnt and advances ptr.
  - The resulting cycle has wr_en=0 and wr_sel=0, but wr_dest/wr_data are still loaded.
  - The FSM treats it as WRITE for sequencing, but stall has no effect on it: no HOLD is entered.
- Undefined: dest=0 is written like any other register.

Test Plan:
- Reset/idle: assert rst mid-run with req=4'b0010 -> all outputs 0 immediately. After release with req=0 -> IDLE, wr_sel=0 for 10 cycles.
- Single write: req=4'b0001, dest0=4'hA, data0=16'h1234 -> next cycle gnt=4'b0001, wr_en=1, wr_dest=4'hA, wr_sel=16'h0400, wr_data=16'h1234. Then IDLE once req drops.
- Round robin: req=4'b1111 held, each requester dropping req on its gnt and re-asserting one cycle later -> grant order 0,1,2,3,0; wr_en high every cycle.
- Stall: grant requester 2 (dest=5, data=16'hBEEF), stall=1 for 3 cycles -> wr_en=1, wr_sel=16'h0020, data stable, gnt=0 throughout. Pending req3 is granted the cycle after stall falls.
- Stall in IDLE: stall=1 with req=4'b0100 -> no gnt. stall=0 -> gnt=4'b0100 next cycle.
- REG_ZERO_PROTECT_EN: req0 with dest0=0 -> gnt=4'b0001, wr_en=0, wr_sel=0. Without the macro -> wr_en=1, wr_sel=16'h0001.
